alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
- REQ-001 Parameter WIDTH, default 32: operand and result width; legal range 8..64.
- REQ-002 Parameter OPW, default 5: ALUOp field width.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rstn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- REQ-005 in_valid  input  1  operation request.
- REQ-006 in_ready  output  1  block can accept a request.
- REQ-007 A, B  input  WIDTH each  operands, signed or unsigned per op.
- REQ-008 ALUOp  input  OPW  operation code.
- REQ-009 out_valid  output  1  result available.
- REQ-010 out_ready  input  1  consumer takes result.
- REQ-011 C  output  WIDTH  registered result.
- REQ-012 Zero  output  1  high when C == 0; registered with C.

Function
- REQ-013 Opcodes SHALL be:
  - 0 nop: C keeps its previous value.
  - 1 lui: C = B.
  - 2 auipc, 3 add: C = A+B.
  - 4 sub: C = A-B.
  - 5 and, 6 or, 7 xor.
  - 8 sll, 9 srl, 10 sra: shift amount B[clog2(WIDTH)-1:0].
  - 11 slt (signed), 12 sltu: C = 1 or 0.
  - 13 mul: low WIDTH bits of product.
  - 14 mulhu: high WIDTH bits of the unsigned product.
  - 15 divu: quotient.
  - 16 remu: remainder.
  - Other codes: C = 0.
- REQ-014 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
- REQ-015 The FSM SHALL have exactly three states:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
- REQ-016 A request SHALL be accepted on a rising edge with in_valid & in_ready; A, B and ALUOp are latched at that edge.
- REQ-017 Ops 0..12 and undefined codes SHALL go IDLE -> DONE, with C valid one cycle after acceptance.
- REQ-018 Ops 13..16 SHALL go IDLE -> BUSY; an iteration counter runs WIDTH cycles (shift-add multiply, restoring divide), then BUSY -> DONE; out_valid rises exactly WIDTH+1 cycles after acceptance.
- REQ-019 In DONE, C and Zero SHALL stay stable while out_ready = 0.
- REQ-020 DONE -> IDLE SHALL occur on the edge where out_ready = 1; the next acceptance is possible one cycle later.
- REQ-021 Inputs presented while in_ready = 0 SHALL be ignored and SHALL NOT corrupt an operation in progress.
- REQ-022 Divide by zero: divu SHALL return all-ones and remu SHALL return A, with the same WIDTH+1 latency.
- REQ-023 Zero SHALL be computed from the final C value, including the nop case.

Reset
- REQ-024 When rstn = 0 at a rising edge:
  - state -> IDLE; C -> 0; Zero -> 1; out_valid -> 0; in_ready -> 1.
  - The iteration counter and partial results are cleared.
- REQ-025 Reset during BUSY or DONE SHALL abort the operation; no out_valid pulse follows.
- REQ-026 in_valid SHALL be ignored while rstn = 0.

Verification
- REQ-027 add, WIDTH=32: A=0x7FFFFFFF, B=1 accepted -> next cycle out_valid=1, C=0x80000000, Zero=0; sub with A=B=5 -> C=0, Zero=1.
- REQ-028 sra: A=0x80000000, B=4 -> C=0xF8000000; slt with A=-1, B=1 -> C=1; sltu with the same operands -> C=0.
- REQ-029 mul: A=0xFFFFFFFF, B=2 -> C=0xFFFFFFFE after exactly 33 cycles; mulhu with the same operands -> C=1; in_ready=0 throughout BUSY.
- REQ-030 divu: A=100, B=7 -> C=14; remu with the same operands -> C=2; divu with B=0 -> C=0xFFFFFFFF; remu with A=9, B=0 -> C=9.
- REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> C stable and in_valid ignored; raise out_ready -> IDLE next cycle.
- REQ-032 Reset: assert rstn=0 mid-BUSY -> next edge C=0, Zero=1, in_ready=1, and no stale out_valid ever appears.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, WIDTH-step shift-add multiply
// and restoring divide, valid/ready handshake on both sides.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             Zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(1);
  localparam logic [OPW-1:0] OP_AUIPC = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5);
  localparam logic [OPW-1:0] OP_OR    = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(7);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(8);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(9);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(10);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(11);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(12);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(13);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(14);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(15);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(16);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] c_q;
  logic             zero_q;
  logic [OPW-1:0]   op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   trial;
  logic [SHW-1:0]   shamt;
  logic             is_iter;
  logic             is_mul_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign C         = c_q;
  assign Zero      = zero_q;

  assign shamt    = B[SHW-1:0];
  assign is_iter  = (ALUOp >= OP_MUL) && (ALUOp <= OP_REMU);
  assign is_mul_q = (op_q == OP_MUL) || (op_q == OP_MULHU);

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      OP_NOP:             alu_res = c_q;
      OP_LUI:             alu_res = B;
      OP_AUIPC, OP_ADD:   alu_res = A + B;
      OP_SUB:             alu_res = A - B;
      OP_AND:             alu_res = A & B;
      OP_OR:              alu_res = A | B;
      OP_XOR:             alu_res = A ^ B;
      OP_SLL:             alu_res = A << shamt;
      OP_SRL:             alu_res = A >> shamt;
      OP_SRA:             alu_res = $signed(A) >>> shamt;
      OP_SLT:             alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:            alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default:            alu_res = '0;
    endcase
  end

  // One iteration step. Multiply: {hi,lo} holds partial product / multiplier,
  // shifted right each step. Divide: hi is the remainder, lo the dividend
  // shifting out into quotient bits; a zero divisor naturally yields
  // quotient all-ones and remainder A.
  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rsh   = {hi_q, lo_q[WIDTH-1]};
    trial = rsh - {1'b0, opnd_q};
    if (is_mul_q) begin
      hi_d = msum[WIDTH:1];
      lo_d = {msum[0], lo_q[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_d = trial[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = rsh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
    iter_res = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_d : lo_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      zero_q      <= 1'b1;
      op_q        <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            op_q       <= ALUOp;
            if (is_iter) begin
              state_q <= S_BUSY;
              cnt_q   <= '0;
              hi_q    <= '0;
              if ((ALUOp == OP_MUL) || (ALUOp == OP_MULHU)) begin
                lo_q   <= B;
                opnd_q <= A;
              end else begin
                lo_q   <= A;
                opnd_q <= B;
              end
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              c_q         <= alu_res;
              zero_q      <= (alu_res == '0);
            end
          end
        end
        S_BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            c_q         <= iter_res;
            zero_q      <= (iter_res == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed vector table, handshake
// corner sequences, and random ops against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALUOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] C;
  logic        Zero;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_c;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .OPW(5)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid),
    .out_ready(out_ready), .C(C), .Zero(Zero)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        z;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] prev);
    logic [63:0] p;
    int          sa;
    int          sb;
    p  = {32'd0, a} * {32'd0, b};
    sa = a;
    sb = b;
    case (op)
      5'd0:        return prev;
      5'd1:        return b;
      5'd2, 5'd3:  return a + b;
      5'd4:        return a - b;
      5'd5:        return a & b;
      5'd6:        return a | b;
      5'd7:        return a ^ b;
      5'd8:        return a << b[4:0];
      5'd9:        return a >> b[4:0];
      5'd10:       return sa >>> b[4:0];
      5'd11:       return (sa < sb) ? 32'd1 : 32'd0;
      5'd12:       return (a < b) ? 32'd1 : 32'd0;
      5'd13:       return p[31:0];
      5'd14:       return p[63:32];
      5'd15:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16:       return (b == 0) ? a : a % b;
      default:     return 32'd0;
    endcase
  endfunction

  // Issue one op at a negedge, count cycles to out_valid while throwing
  // junk at the inputs, hold the result for `hold` cycles, then release.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expc, input logic expz, input int hold);
    int lat;
    int exp_lat;
    bit busy_bad;
    exp_lat = (op >= 13 && op <= 16) ? 33 : 1;
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_bad = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      A = $urandom; B = $urandom; ALUOp = 5'($urandom);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency op%0d", op), lat, exp_lat);
    chk("in_ready_low_while_busy", busy_bad, 0);
    chk($sformatf("C op%0d a=%0h b=%0h", op, a, b), C, expc);
    chk($sformatf("Zero op%0d", op), Zero, expz);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; A = $urandom; B = $urandom; ALUOp = 5'($urandom_range(0, 12));
      @(negedge clk);
      chk("C_stable_backpressure", C, expc);
      chk("out_valid_held", out_valid, 1);
      chk("in_ready_low_in_done", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_dropped", out_valid, 0);
    chk("in_ready_after_release", in_ready, 1);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ec;
    bit          seen;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUOp = '0;
    tbl.push_back('{5'd3,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0});
    tbl.push_back('{5'd4,  32'd5,         32'd5,         32'd0,         1'b1});
    tbl.push_back('{5'd0,  32'd123,       32'd456,       32'd0,         1'b1});
    tbl.push_back('{5'd1,  32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{5'd0,  32'd1,         32'd2,         32'hDEAD_BEEF, 1'b0});
    tbl.push_back('{5'd2,  32'd10,        32'd20,        32'd30,        1'b0});
    tbl.push_back('{5'd3,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1});
    tbl.push_back('{5'd5,  32'hF0F0_FFFF, 32'h0000_0FF0, 32'h0000_0FF0, 1'b0});
    tbl.push_back('{5'd6,  32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0});
    tbl.push_back('{5'd7,  32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0});
    tbl.push_back('{5'd8,  32'd1,         32'd31,        32'h8000_0000, 1'b0});
    tbl.push_back('{5'd8,  32'd1,         32'd35,        32'd8,         1'b0});
    tbl.push_back('{5'd9,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0});
    tbl.push_back('{5'd10, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0});
    tbl.push_back('{5'd11, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0});
    tbl.push_back('{5'd12, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1});
    tbl.push_back('{5'd13, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{5'd14, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0});
    tbl.push_back('{5'd13, 32'd0,         32'h1234_5678, 32'd0,         1'b1});
    tbl.push_back('{5'd15, 32'd100,       32'd7,         32'd14,        1'b0});
    tbl.push_back('{5'd16, 32'd100,       32'd7,         32'd2,         1'b0});
    tbl.push_back('{5'd15, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{5'd16, 32'd9,         32'd0,         32'd9,         1'b0});
    tbl.push_back('{5'd15, 32'd7,         32'd100,       32'd0,         1'b1});
    tbl.push_back('{5'd16, 32'd7,         32'd100,       32'd7,         1'b0});
    tbl.push_back('{5'd17, 32'd3,         32'd4,         32'd0,         1'b1});
    tbl.push_back('{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b1});

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_C", C, 0);
    chk("reset_Zero", Zero, 1);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].z, 0);

    // Backpressure: 5 cycles of out_ready=0 with in_valid pulsing
    do_op(5'd7, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 1'b0, 5);
    do_op(5'd15, 32'd1000, 32'd10, 32'd100, 1'b0, 5);
    model_c = 32'd100;

    // Reset in the middle of a multiply
    in_valid = 1'b1; ALUOp = 5'd13; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_in_ready", in_ready, 0);
    chk("busy_out_valid", out_valid, 0);
    rstn = 1'b0; in_valid = 1'b1; ALUOp = 5'd1; A = 32'd1; B = 32'd77;
    @(negedge clk);
    chk("abort_C", C, 0);
    chk("abort_Zero", Zero, 1);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    @(negedge clk);
    chk("in_valid_ignored_in_reset_C", C, 0);
    chk("in_valid_ignored_in_reset_rdy", in_ready, 1);
    rstn = 1'b1; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_out_valid", seen, 0);
    model_c = 32'd0;
    do_op(5'd0, 32'd5, 32'd6, 32'd0, 1'b1, 0);

    // Random ops against the reference model
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 19));
      case ($urandom_range(0, 3))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = $urandom_range(0, 40);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      ec = ref_alu(op, a, b, model_c);
      do_op(op, a, b, ec, (ec == 32'd0), $urandom_range(0, 3));
      model_c = ec;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
